pipelined_adder: RTL



---
 rtl/pipelined_adder_pkg.sv | 13 +
 rtl/pipelined_adder_if.sv | 39 +++
 rtl/pipelined_adder_add_slice.sv | 31 +++
 rtl/pipelined_adder.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// Optional feature macro used across the block: PADD_OVF_EN (signed overflow flag).
package padd_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Number of pipeline stages: one stage per SLICE-bit segment.
   function automatic int calc_stages(input int width, input int slice);
      return width / slice;
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The ovf signal exists only when PADD_OVF_EN is defined.
interface padd_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef PADD_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout
   );
`endif
endinterface

// File: rtl/pipelined_adder_add_slice.sv
// Combinational SLICE-bit adder segment with carry in/out.
// cmsb_o (carry into the slice MSB) is present only with PADD_OVF_EN.
module add_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             c_i,
   output logic [SLICE-1:0] s_o,
`ifdef PADD_OVF_EN
   output logic             cmsb_o,
`endif
   output logic             c_o
);

   logic [SLICE:0] total;

   // Full slice addition; the extra bit is the slice carry-out.
   always_comb begin
      total = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, c_i};
   end

   assign s_o = total[SLICE-1:0];
   assign c_o = total[SLICE];

`ifdef PADD_OVF_EN
   // The MSB sum bit is a^b^carry_in, so the carry into the MSB is recovered by XOR.
   assign cmsb_o = a_i[SLICE-1] ^ b_i[SLICE-1] ^ total[SLICE-1];
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: one SLICE-bit segment per stage, carry registered
// between stages, operand skew and result de-skew, valid/ready with global stall.
// Optional macro PADD_OVF_EN adds a registered two's-complement overflow flag.
module pipelined_adder
   import padd_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic   clk,
   input logic   rst,
   padd_if.slave bus
);

   localparam int STAGES = calc_stages(WIDTH, SLICE);

   if (WIDTH % SLICE != 0) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of SLICE");
   end

   // Whole pipeline advances unless a finished result is being held back.
   logic en;
   assign en           = !(bus.out_valid && !bus.out_ready);
   assign bus.in_ready = en;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] r_src;
      logic             c_src;
      logic             v_src;
      logic [SLICE-1:0] s_slice;
      logic             s_carry;
      logic [WIDTH-1:0] res_d;
      logic [WIDTH-1:0] res_q;
      logic             c_q;
      logic             vld_q;
`ifdef PADD_OVF_EN
      logic             c_msb;
`endif

      if (k == 0) begin : g_first
         // Subtraction is a + ~b + 1; cin only matters when adding.
         assign a_src = bus.a;
         assign b_src = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
         assign c_src = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
         assign v_src = bus.in_valid;
         assign r_src = '0;
      end else begin : g_next
         assign a_src = g_stage[k-1].g_skew.a_q;
         assign b_src = g_stage[k-1].g_skew.b_q;
         assign c_src = g_stage[k-1].c_q;
         assign v_src = g_stage[k-1].vld_q;
         assign r_src = g_stage[k-1].res_q;
      end

      add_slice #(
         .SLICE (SLICE)
      ) u_slice (
         .a_i    (a_src[k*SLICE +: SLICE]),
         .b_i    (b_src[k*SLICE +: SLICE]),
         .c_i    (c_src),
         .s_o    (s_slice),
`ifdef PADD_OVF_EN
         .cmsb_o (c_msb),
`endif
         .c_o    (s_carry)
      );

      // Merge this stage's slice into the de-skewed partial result.
      always_comb begin
         res_d                    = r_src;
         res_d[k*SLICE +: SLICE]  = s_slice;
      end

      // Valid bit for this stage; bubbles travel as zeros.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
         end else if (en) begin
            vld_q <= v_src;
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;

         // Operand skew registers carry the not-yet-added upper slices forward.
         always_ff @(posedge clk) begin
            if (en) begin
               a_q <= a_src;
               b_q <= b_src;
            end
         end

         // Partial result and inter-stage carry.
         always_ff @(posedge clk) begin
            if (en) begin
               res_q <= res_d;
               c_q   <= s_carry;
            end
         end
      end else begin : g_last
         // Output register: cleared on reset so the visible result starts at zero.
         always_ff @(posedge clk) begin
            if (rst) begin
               res_q <= '0;
               c_q   <= 1'b0;
            end else if (en) begin
               res_q <= res_d;
               c_q   <= s_carry;
            end
         end

`ifdef PADD_OVF_EN
         logic ovf_q;

         // Signed overflow: carry into MSB differs from carry out of MSB.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (en) begin
               ovf_q <= c_msb ^ s_carry;
            end
         end
`endif
      end
   end

   assign bus.out_valid = g_stage[STAGES-1].vld_q;
   assign bus.sum       = g_stage[STAGES-1].res_q;
   assign bus.cout      = g_stage[STAGES-1].c_q;
`ifdef PADD_OVF_EN
   assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;
`endif

endmodule
